// File: rtl/dsc_mul_seq_if.sv
// Bus bundle for dsc_mul_seq: operand handshake, multiplier control and result handshake.
// The slave modport is the sequencer side, master is the surrounding environment.
interface dsc_mul_seq_if #(
   parameter int unsigned SNG_WIDTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [SNG_WIDTH-1:0]     in_a;
   logic [SNG_WIDTH-1:0]     in_b;
   logic [SNG_WIDTH-1:0]     mul_a;
   logic [SNG_WIDTH-1:0]     mul_b;
   logic                     mul_clr;
   logic                     mul_en;
   logic [2*SNG_WIDTH-1:0]   mul_z;
   logic                     mul_ov;
   logic                     res_valid;
   logic                     res_ready;
   logic [2*SNG_WIDTH-1:0]   res_z;
   logic [15:0]              res_cycles;
   logic                     res_timeout;
   logic                     busy;

   modport slave (
      input  in_valid, in_a, in_b, mul_z, mul_ov, res_ready,
      output in_ready, mul_a, mul_b, mul_clr, mul_en,
      output res_valid, res_z, res_cycles, res_timeout, busy
   );

   modport master (
      output in_valid, in_a, in_b, mul_z, mul_ov, res_ready,
      input  in_ready, mul_a, mul_b, mul_clr, mul_en,
      input  res_valid, res_z, res_cycles, res_timeout, busy
   );
endinterface

// File: rtl/dsc_mul_seq.sv
// Operand sequencer and result capture for the stochastic multiplier: clear, run until
// overflow or timeout, settle, then hold the captured product for a downstream handshake.
module dsc_mul_seq #(
   parameter int unsigned SNG_WIDTH  = 4,
   parameter int unsigned MAX_CYCLES = 300,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic           clk,
   input  logic           rst,
   dsc_mul_seq_if.slave   bus
);

   typedef enum logic [2:0] {StIdle, StClear, StRun, StSettle, StHold} state_e;

   localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

   state_e                 r_state, w_state_nxt;
   logic [15:0]            r_cnt, w_cnt_nxt;
   logic                   r_to, w_to_nxt;
   logic [3:0]             r_settle, w_settle_nxt;
   logic [SNG_WIDTH-1:0]   r_mul_a, r_mul_b;
   logic                   r_mul_clr, r_mul_en;
   logic                   r_res_valid;
   logic [2*SNG_WIDTH-1:0] r_res_z;
   logic [15:0]            r_res_cycles;
   logic                   r_res_timeout;

   logic                   w_accept;
   logic                   w_capture;
   logic [15:0]            w_cnt_inc;
   logic                   w_max_hit;

   assign w_accept  = (r_state == StIdle) && bus.in_valid;
   assign w_capture = (r_state == StSettle) && (r_settle == SettleLast);
   assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
   // Compare in 32 bits so a saturated counter never aliases a small limit.
   assign w_max_hit = ((32'(r_cnt) + 32'd1) >= 32'(MAX_CYCLES));

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_to_nxt     = r_to;
      w_settle_nxt = r_settle;
      unique case (r_state)
         StIdle: begin
            if (bus.in_valid) w_state_nxt = StClear;
         end
         StClear: begin
            w_cnt_nxt    = '0;
            w_to_nxt     = 1'b0;
            w_settle_nxt = '0;
            w_state_nxt  = StRun;
         end
         StRun: begin
            w_cnt_nxt = w_cnt_inc;
            // ov in the first RUN cycle is the stale flag left over from the clear.
            if ((r_cnt != 16'd0) && bus.mul_ov) begin
               w_state_nxt  = StSettle;
               w_settle_nxt = '0;
            end else if (w_max_hit) begin
               w_to_nxt     = 1'b1;
               w_state_nxt  = StSettle;
               w_settle_nxt = '0;
            end
         end
         StSettle: begin
            if (r_settle == SettleLast) w_state_nxt = StHold;
            else                        w_settle_nxt = r_settle + 4'd1;
         end
         StHold: begin
            if (bus.res_ready) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_to          <= 1'b0;
         r_settle      <= '0;
         r_mul_a       <= '0;
         r_mul_b       <= '0;
         r_mul_clr     <= 1'b0;
         r_mul_en      <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_z       <= '0;
         r_res_cycles  <= '0;
         r_res_timeout <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_to        <= w_to_nxt;
         r_settle    <= w_settle_nxt;
         r_mul_clr   <= (w_state_nxt == StClear);
         r_mul_en    <= (w_state_nxt == StRun);
         r_res_valid <= (w_state_nxt == StHold);
         if (w_accept) begin
            r_mul_a <= bus.in_a;
            r_mul_b <= bus.in_b;
         end
         if (w_capture) begin
            r_res_z       <= bus.mul_z;
            r_res_cycles  <= r_cnt;
            r_res_timeout <= r_to;
         end
      end
   end

   assign bus.in_ready    = (r_state == StIdle);
   assign bus.busy        = (r_state != StIdle);
   assign bus.mul_a       = r_mul_a;
   assign bus.mul_b       = r_mul_b;
   assign bus.mul_clr     = r_mul_clr;
   assign bus.mul_en      = r_mul_en;
   assign bus.res_valid   = r_res_valid;
   assign bus.res_z       = r_res_z;
   assign bus.res_cycles  = r_res_cycles;
   assign bus.res_timeout = r_res_timeout;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Randomized bench for dsc_mul_seq: a timeline model predicts every output each cycle,
// with directed transactions pinning latency, ov masking, timeout and backpressure.
module tb_dsc_mul_seq;
   localparam int unsigned W    = 4;
   localparam int unsigned MAXC = 300;
   localparam int unsigned SET  = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   dsc_mul_seq_if #(.SNG_WIDTH(W)) bus ();

   dsc_mul_seq #(
      .SNG_WIDTH (W),
      .MAX_CYCLES(MAXC),
      .SETTLE_CYC(SET)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stand-in multiplier: ov rises in RUN cycle ov_at (0 = never); z is wrong while enabled.
   int          ov_at   = 0;
   logic [7:0]  zval    = 8'h00;
   int          run_cnt = 0;
   always @(posedge clk) begin
      if (bus.mul_clr)     run_cnt <= 0;
      else if (bus.mul_en) run_cnt <= run_cnt + 1;
   end
   assign bus.mul_ov = (ov_at != 0) && (run_cnt + 1 >= ov_at);
   assign bus.mul_z  = bus.mul_en ? ~zval : zval;

   // Reference model: one transaction as a timeline of cycle offsets from its CLEAR cycle.
   bit         m_busy = 1'b0;
   int         m_acc, m_n, m_hold;
   bit         m_to;
   logic [7:0] m_z;
   logic [3:0] m_a = '0, m_b = '0;
   logic [7:0] lr_z = '0;
   logic [15:0] lr_cyc = '0;
   bit         lr_to = 1'b0;
   bit         e_clr, e_en, e_rv;
   int         stop;

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("rst in_ready", bus.in_ready, 1);
         chk("rst busy", bus.busy, 0);
         chk("rst mul_a", bus.mul_a, 0);
         chk("rst mul_b", bus.mul_b, 0);
         chk("rst mul_clr", bus.mul_clr, 0);
         chk("rst mul_en", bus.mul_en, 0);
         chk("rst res_valid", bus.res_valid, 0);
         chk("rst res_z", bus.res_z, 0);
         chk("rst res_cycles", bus.res_cycles, 0);
         chk("rst res_timeout", bus.res_timeout, 0);
         m_busy = 1'b0; m_a = '0; m_b = '0;
         lr_z = '0; lr_cyc = '0; lr_to = 1'b0;
      end else begin
         e_clr = m_busy && (cyc == m_acc);
         e_en  = m_busy && (cyc > m_acc) && (cyc <= m_acc + m_n);
         e_rv  = m_busy && (cyc >= m_hold);
         chk("in_ready", bus.in_ready, !m_busy);
         chk("busy", bus.busy, m_busy);
         chk("mul_clr", bus.mul_clr, e_clr);
         chk("mul_en", bus.mul_en, e_en);
         chk("res_valid", bus.res_valid, e_rv);
         chk("mul_a", bus.mul_a, m_a);
         chk("mul_b", bus.mul_b, m_b);
         if (e_rv) begin
            chk("res_z", bus.res_z, m_z);
            chk("res_cycles", bus.res_cycles, m_n);
            chk("res_timeout", bus.res_timeout, m_to);
         end else begin
            chk("res_z kept", bus.res_z, lr_z);
            chk("res_cycles kept", bus.res_cycles, lr_cyc);
            chk("res_timeout kept", bus.res_timeout, lr_to);
         end
         if (e_rv && bus.res_ready) begin
            lr_z = m_z; lr_cyc = 16'(m_n); lr_to = m_to;
            m_busy = 1'b0;
         end else if (!m_busy && bus.in_valid) begin
            m_busy = 1'b1;
            m_acc  = cyc + 1;
            m_a    = bus.in_a;
            m_b    = bus.in_b;
            m_z    = zval;
            stop   = (ov_at < 2) ? 2 : ov_at;
            if (ov_at != 0 && stop <= int'(MAXC)) begin
               m_n = stop; m_to = 1'b0;
            end else begin
               m_n = MAXC; m_to = 1'b1;
            end
            m_hold = m_acc + 1 + m_n + SET;
         end
      end
   end

   task automatic wait_ready(output int acc_c);
      bit ok = 1'b0;
      acc_c = cyc;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1 && bus.in_valid) begin
            acc_c = cyc; ok = 1'b1; break;
         end
      end
      if (!ok) chk("accept timeout", 0, 1);
   endtask

   task automatic wait_valid(input int acc_c, output int lat);
      bit ok = 1'b0;
      lat = -1;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (bus.res_valid === 1'b1) begin
            lat = cyc - acc_c; ok = 1'b1; break;
         end
      end
      if (!ok) chk("res_valid timeout", 0, 1);
   endtask

   task automatic txn(input logic [3:0] a, input logic [3:0] b, input int ov,
                      input logic [7:0] z, input int dly, output int lat,
                      output logic [7:0] rz, output logic [15:0] rc, output logic rt);
      int acc;
      @(posedge clk); #1;
      bus.in_a = a; bus.in_b = b; ov_at = ov; zval = z;
      bus.in_valid = 1'b1; bus.res_ready = (dly == 0);
      wait_ready(acc);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      wait_valid(acc, lat);
      rz = bus.res_z; rc = bus.res_cycles; rt = bus.res_timeout;
      if (dly > 0) begin
         repeat (dly) @(posedge clk);
         #1 bus.res_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1 bus.res_ready = 1'b0;
   endtask

   int          lat, acc;
   logic [7:0]  rz;
   logic [15:0] rc;
   logic        rt;
   int          r;

   initial begin
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;

      // ov in 5th RUN cycle
      txn(4'd3, 4'd9, 5, 8'h2A, 2, lat, rz, rc, rt);
      chk("lit5 res_z", rz, 8'h2A);
      chk("lit5 res_cycles", rc, 5);
      chk("lit5 res_timeout", rt, 0);
      chk("lit5 latency", lat, 9);
      chk("lit5 mul_a held", bus.mul_a, 3);
      chk("lit5 mul_b held", bus.mul_b, 9);

      // ov high from CLEAR: first RUN cycle masked
      txn(4'd7, 4'd0, 1, 8'h00, 0, lat, rz, rc, rt);
      chk("ov0 res_z", rz, 8'h00);
      chk("ov0 res_cycles", rc, 2);
      chk("ov0 res_timeout", rt, 0);
      chk("ov0 latency", lat, 6);

      // no ov: timeout
      txn(4'd1, 4'd1, 0, 8'h5C, 1, lat, rz, rc, rt);
      chk("tmo res_cycles", rc, 300);
      chk("tmo res_timeout", rt, 1);
      chk("tmo latency", lat, 304);

      // ov coincides with limit: ov wins
      txn(4'd2, 4'd2, 300, 8'hC3, 0, lat, rz, rc, rt);
      chk("tie res_cycles", rc, 300);
      chk("tie res_timeout", rt, 0);
      chk("tie res_z", rz, 8'hC3);

      // Backpressure with next operands waiting
      @(posedge clk); #1;
      bus.in_a = 4'd5; bus.in_b = 4'd6; ov_at = 7; zval = 8'h77;
      bus.in_valid = 1'b1; bus.res_ready = 1'b0;
      wait_ready(acc);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      wait_valid(acc, lat);
      @(posedge clk); #1;
      bus.in_a = 4'd10; bus.in_b = 4'd11; ov_at = 3; zval = 8'h33; bus.in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("bp in_ready", bus.in_ready, 0);
         chk("bp res_valid", bus.res_valid, 1);
         chk("bp res_z", bus.res_z, 8'h77);
         chk("bp res_cycles", bus.res_cycles, 7);
      end
      @(posedge clk); #1 bus.res_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 bus.res_ready = 1'b0;
      @(negedge clk);
      chk("b2b in_ready after handshake", bus.in_ready, 1);
      acc = cyc;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      wait_valid(acc, lat);
      chk("b2b res_z", bus.res_z, 8'h33);
      chk("b2b res_cycles", bus.res_cycles, 3);
      chk("b2b latency", lat, 7);
      @(posedge clk); #1 bus.res_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 bus.res_ready = 1'b0;

      // Asynchronous reset in the middle of a run
      @(posedge clk); #1;
      bus.in_a = 4'd4; bus.in_b = 4'd12; ov_at = 0; zval = 8'h11; bus.in_valid = 1'b1;
      wait_ready(acc);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #2 chk("pre-reset mul_en", bus.mul_en, 1);
      #1 rst = 1'b0;
      #1;
      chk("async mul_en", bus.mul_en, 0);
      chk("async mul_a", bus.mul_a, 0);
      chk("async res_z", bus.res_z, 0);
      chk("async res_cycles", bus.res_cycles, 0);
      chk("async in_ready", bus.in_ready, 1);
      chk("async busy", bus.busy, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;

      // Randomized transactions, checked by the model every cycle
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0:       ov_at = 0;
            1:       ov_at = 1;
            2:       ov_at = MAXC;
            3:       ov_at = MAXC + 1;
            default: ov_at = $urandom_range(2, 40);
         endcase
         txn(4'($urandom), 4'($urandom), ov_at, 8'($urandom), $urandom_range(0, 3),
             lat, rz, rc, rt);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dsc_mul_seq.md
# dsc_mul_seq

Operand sequencer and result-capture stage for the 4-lane stochastic multiplier. Accepts one operand pair per transaction over a valid/ready handshake. Holds the operands stable on the multiplier inputs, clears the multiplier, enables it until it signals overflow/termination, and waits for the parallel accumulator to settle. It then captures the binary product and presents it downstream with a valid/ready handshake, the run-length cycle count and a timeout flag.

## Interface
- SNG_WIDTH, 4, operand width; product width is 2*SNG_WIDTH
- MAX_CYCLES, 300, RUN cycles after which the run is force-terminated with timeout set; legal range 2..65535
- SETTLE_CYC, 2, idle cycles between end of RUN and product capture; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept operands
- in_a, in_b  in  SNG_WIDTH  operands
- mul_a, mul_b  out  SNG_WIDTH  registered operands to the multiplier
- mul_clr  out  1  active-high synchronous clear to the multiplier
- mul_en  out  1  multiplier enable
- mul_z  in  2*SNG_WIDTH  accumulated product from the multiplier
- mul_ov  in  1  multiplier termination flag
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_z  out  2*SNG_WIDTH  captured product
- res_cycles  out  16  number of RUN cycles, saturating at 0xFFFF
- res_timeout  out  1  run ended by MAX_CYCLES, not by mul_ov
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, CLEAR, RUN, SETTLE, HOLD.
- IDLE: in_ready=1. When in_valid=1 at a clock edge:
  - latch in_a/in_b into mul_a/mul_b;
  - go to CLEAR.
- CLEAR (1 cycle): mul_clr=1, mul_en=0; clear the run counter and the timeout flag; go to RUN.
- RUN: mul_en=1 and the run counter increments every cycle.
  - mul_ov is ignored in the first RUN cycle (counter==0), to mask the stale flag following a clear.
  - When counter>=1 and mul_ov=1: go to SETTLE. The cycle in which ov is sampled counts as a RUN cycle.
  - Else if the counter reaches MAX_CYCLES: set timeout and go to SETTLE. mul_ov and the timeout in the same cycle resolve as ov, with timeout=0.
- SETTLE: mul_en=0 for SETTLE_CYC cycles. On the last SETTLE edge:
  - register mul_z into res_z;
  - register the counter into res_cycles;
  - go to HOLD.
- HOLD: res_valid=1, and res_z/res_cycles/res_timeout stay stable. On res_valid&res_ready go to IDLE.
- in_ready=0 in every state except IDLE. There is no back-to-back overlap: the earliest next acceptance is the cycle after the HOLD handshake.
- mul_a/mul_b stay held from acceptance until the next acceptance; they do not change in HOLD.
- res_* fields persist after the handshake until the next capture. res_valid alone qualifies them.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, and all of the following are 0:
  - mul_a, mul_b, mul_clr, mul_en;
  - res_valid, res_z, res_cycles, res_timeout, busy.
- in_ready=1 is combinational from state, so it is 1 during reset.
- Reset release mid-run: the sequencer restarts in IDLE and the in-flight result is discarded.
- Acceptance at edge k:
  - CLEAR is cycle k+1;
  - RUN starts at k+2;
  - for a run of N cycles, SETTLE occupies k+2+N .. k+1+N+SETTLE_CYC;
  - res_valid rises at edge k+2+N+SETTLE_CYC.
- Total latency from acceptance to res_valid = 2+N+SETTLE_CYC cycles.
- res_cycles: a 16-bit counter that saturates. It only exceeds 65535 if MAX_CYCLES does; that setting is not legal, but the counter still saturates and does not wrap.
- res_ready may be held high in advance; the handshake then completes in the first HOLD cycle.
- All outputs are registered except in_ready and busy, which decode the state.

## Test plan
- Reset with rst=0 during RUN (mul_en=1) -> all registered outputs 0 immediately (asynchronous); in_ready=1 after release.
- Model asserts mul_ov in the 5th RUN cycle with mul_z=0x2A; in_a=3, in_b=9 -> mul_a=3, mul_b=9; mul_clr for 1 cycle; res_z=0x2A, res_cycles=5, res_timeout=0; res_valid 9 cycles after acceptance (SETTLE_CYC=2).
- mul_ov held high from CLEAR onward (b=0 case) -> first RUN cycle ignored; res_cycles=2, res_z=0x00.
- mul_ov never asserted, MAX_CYCLES=300 -> res_timeout=1, res_cycles=300, mul_en low after 300 RUN cycles.
- res_ready held low 10 cycles in HOLD while in_valid=1 -> res_* stable, in_ready=0; in_ready=1 the cycle after the handshake; the second operand pair is accepted then.
- mul_ov rises on the same cycle the counter hits MAX_CYCLES -> res_timeout=0, res_cycles=MAX_CYCLES.
